// File: rtl/biu_mem_arbiter_pkg.sv
// Shared encodings and widths for the fetch/LSU memory-port arbiter.
// Optional macro BIU_ARB_PERF_CNT_EN enables the top-level grant/conflict counters.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BIU_ARB_IDLE
`define BIU_ARB_IDLE 1'b0
`define BIU_ARB_WAIT 1'b1
`endif
`ifndef BIU_OWN_IFU
`define BIU_OWN_IFU 1'b0
`define BIU_OWN_LSU 1'b1
`endif

package biu_mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = `BIU_ARB_IDLE,
    ARB_WAIT = `BIU_ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = `BIU_OWN_IFU,
    OWN_LSU = `BIU_OWN_LSU
  } owner_e;

  localparam int PERF_W = 32;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/biu_mem_arbiter_if.sv
// Bundle of the fetch, LSU and memory handshake channels around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface biu_mem_arbiter_if #(
  parameter int ADDR_W = `PC_SIZE,
  parameter int DATA_W = `XLEN,
  parameter int MASK_W = DATA_W / 8
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_pc;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_ready;
  logic [DATA_W-1:0] ifu_rsp_instr;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_ready;
  logic [DATA_W-1:0] lsu_rsp_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/biu_mem_arbiter_rr_sel2.sv
// Two-way round-robin pick between fetch and LSU; on a tie the side that
// was not served last wins.
module biu_rr_sel2
  import biu_mem_arbiter_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_e last_served,
  output owner_e sel,
  output logic   conflict
);

  always_comb begin
    sel      = OWN_IFU;
    conflict = ifu_valid & lsu_valid;
    if (conflict) begin
      sel = (last_served == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end else if (lsu_valid) begin
      sel = OWN_LSU;
    end
  end

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// Generic load-enabled flop with synchronous active-high reset to RST_VAL.
module sirv_gnrl_dfflr #(
  parameter int            DW      = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= RST_VAL;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/biu_mem_arbiter.sv
// Fetch/LSU arbiter for the single memory port: one outstanding transaction,
// round-robin grant. Optional macro BIU_ARB_PERF_CNT_EN adds perf counters.
//
// state    | meaning
// ARB_IDLE | no transaction in flight; selected request forwarded to memory
// ARB_WAIT | request accepted; waiting to route the response to its owner
module biu_mem_arbiter
  import biu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = `PC_SIZE,
  parameter int DATA_W = `XLEN,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic clk,
  input  logic rst,
  biu_mem_arbiter_if.master bus,
`ifdef BIU_ARB_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_ifu_grants,
  output logic [PERF_W-1:0] perf_lsu_grants,
  output logic [PERF_W-1:0] perf_conflict_cycles,
`endif
  output logic arb_busy
);

  logic       state_r;
  logic       state_nxt;
  logic       owner_r;
  logic       last_r;
  arb_state_e state;
  owner_e     owner;
  owner_e     last_served;
  owner_e     sel;
  logic       conflict;

  logic       idle;
  logic       waiting;
  logic       req_any;
  logic       grant_hs;
  logic       rsp_hs;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wen;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_wmask;

  assign state       = arb_state_e'(state_r);
  assign owner       = owner_e'(owner_r);
  assign last_served = owner_e'(last_r);

  biu_rr_sel2 u_sel (
    .ifu_valid   (bus.ifu_req_valid),
    .lsu_valid   (bus.lsu_req_valid),
    .last_served (last_served),
    .sel         (sel),
    .conflict    (conflict)
  );

  // Reset gating keeps every handshake output low while rst is held,
  // even if the state flop still reads WAIT during that cycle.
  assign idle     = ~rst & (state == ARB_IDLE);
  assign waiting  = ~rst & (state == ARB_WAIT);
  assign req_any  = bus.ifu_req_valid | bus.lsu_req_valid;
  assign grant_hs = idle & req_any & bus.mem_req_ready;

  always_comb begin
    sel_addr  = bus.ifu_req_pc;
    sel_wen   = 1'b0;
    sel_wdata = '0;
    sel_wmask = '0;
    if (sel == OWN_LSU) begin
      sel_addr  = bus.lsu_req_addr;
      sel_wen   = bus.lsu_req_wen;
      sel_wdata = bus.lsu_req_wdata;
      sel_wmask = bus.lsu_req_wmask;
    end
  end

  assign bus.mem_req_valid = idle & req_any;
  assign bus.mem_req_addr  = sel_addr;
  assign bus.mem_req_wen   = sel_wen;
  assign bus.mem_req_wdata = sel_wdata;
  assign bus.mem_req_wmask = sel_wmask;
  assign bus.ifu_req_ready = idle & bus.ifu_req_valid & (sel == OWN_IFU) & bus.mem_req_ready;
  assign bus.lsu_req_ready = idle & bus.lsu_req_valid & (sel == OWN_LSU) & bus.mem_req_ready;

  assign bus.ifu_rsp_valid = waiting & (owner == OWN_IFU) & bus.mem_rsp_valid;
  assign bus.lsu_rsp_valid = waiting & (owner == OWN_LSU) & bus.mem_rsp_valid;
  assign bus.ifu_rsp_instr = bus.mem_rsp_rdata;
  assign bus.lsu_rsp_rdata = bus.mem_rsp_rdata;
  assign bus.mem_rsp_ready = waiting & ((owner == OWN_IFU) ? bus.ifu_rsp_ready : bus.lsu_rsp_ready);
  assign rsp_hs            = bus.mem_rsp_valid & bus.mem_rsp_ready;

  assign arb_busy = waiting;

  always_comb begin
    state_nxt = state_r;
    case (state)
      ARB_IDLE: if (grant_hs) state_nxt = `BIU_ARB_WAIT;
      ARB_WAIT: if (rsp_hs)   state_nxt = `BIU_ARB_IDLE;
      default:                state_nxt = `BIU_ARB_IDLE;
    endcase
  end

  sirv_gnrl_dfflr #(.DW(1), .RST_VAL(`BIU_ARB_IDLE)) u_state_ff (
    .clk(clk), .rst(rst), .lden(1'b1), .dnxt(state_nxt), .qout(state_r)
  );

  sirv_gnrl_dfflr #(.DW(1), .RST_VAL(`BIU_OWN_IFU)) u_owner_ff (
    .clk(clk), .rst(rst), .lden(grant_hs), .dnxt(sel), .qout(owner_r)
  );

  // Boot with LSU as last served so fetch wins the first tie.
  sirv_gnrl_dfflr #(.DW(1), .RST_VAL(`BIU_OWN_LSU)) u_last_ff (
    .clk(clk), .rst(rst), .lden(grant_hs), .dnxt(sel), .qout(last_r)
  );

`ifdef BIU_ARB_PERF_CNT_EN
  sirv_gnrl_dfflr #(.DW(PERF_W)) u_perf_ifu_ff (
    .clk(clk), .rst(rst), .lden(grant_hs & (sel == OWN_IFU)),
    .dnxt(sat_inc(perf_ifu_grants)), .qout(perf_ifu_grants)
  );

  sirv_gnrl_dfflr #(.DW(PERF_W)) u_perf_lsu_ff (
    .clk(clk), .rst(rst), .lden(grant_hs & (sel == OWN_LSU)),
    .dnxt(sat_inc(perf_lsu_grants)), .qout(perf_lsu_grants)
  );

  sirv_gnrl_dfflr #(.DW(PERF_W)) u_perf_conf_ff (
    .clk(clk), .rst(rst), .lden(idle & conflict),
    .dnxt(sat_inc(perf_conflict_cycles)), .qout(perf_conflict_cycles)
  );
`endif

endmodule

// File: tb/tb_biu_mem_arbiter.sv
// Self-checking bench for biu_mem_arbiter: directed scenarios, then random
// traffic against a transaction-level reference model.
module tb_biu_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic arb_busy;
  int   checks = 0;
  int   errors = 0;

  biu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(4)) bus ();

`ifdef BIU_ARB_PERF_CNT_EN
  logic [31:0] p_ifu, p_lsu, p_conf;
`endif

  biu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
`ifdef BIU_ARB_PERF_CNT_EN
    .perf_ifu_grants      (p_ifu),
    .perf_lsu_grants      (p_lsu),
    .perf_conflict_cycles (p_conf),
`endif
    .arb_busy (arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.ifu_req_valid = 1'b0; bus.ifu_req_pc = '0; bus.ifu_rsp_ready = 1'b0;
    bus.lsu_req_valid = 1'b0; bus.lsu_req_addr = '0; bus.lsu_req_wen = 1'b0;
    bus.lsu_req_wdata = '0;   bus.lsu_req_wmask = '0; bus.lsu_rsp_ready = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // reference model state
  bit          busy, own, prev, win, ip, lp, mr, mrv, ir, lr;
  int          g_i, g_l, conf;
  logic [31:0] ipc, laddr, lwd, rd;
  logic        lwen;
  logic [3:0]  lwm;

  initial begin
    clear();
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1; bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1; bus.ifu_rsp_ready = 1'b1; bus.lsu_rsp_ready = 1'b1;
    tick(); tick(); #1;
    chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 0);
    chk("rst_ifu_req_ready", 32'(bus.ifu_req_ready), 0);
    chk("rst_lsu_req_ready", 32'(bus.lsu_req_ready), 0);
    chk("rst_mem_rsp_ready", 32'(bus.mem_rsp_ready), 0);
    chk("rst_ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 0);
    chk("rst_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 0);
    chk("rst_busy", 32'(arb_busy), 0);
    clear(); rst = 1'b0; tick();

    // stray response while idle
    bus.mem_rsp_valid = 1'b1; bus.ifu_rsp_ready = 1'b1; #1;
    chk("idle_rsp_ready", 32'(bus.mem_rsp_ready), 0);
    chk("idle_rsp_fwd", 32'(bus.ifu_rsp_valid), 0);
    clear(); tick();

    // fetch only
    bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0000; bus.mem_req_ready = 1'b1; #1;
    chk("fetch_valid", 32'(bus.mem_req_valid), 1);
    chk("fetch_addr", bus.mem_req_addr, 32'h8000_0000);
    chk("fetch_wen", 32'(bus.mem_req_wen), 0);
    chk("fetch_wmask", 32'(bus.mem_req_wmask), 0);
    chk("fetch_ready", 32'(bus.ifu_req_ready), 1);
    tick(); clear(); #1;
    chk("fetch_busy", 32'(arb_busy), 1);
    chk("fetch_wait_noreq", 32'(bus.mem_req_valid), 0);
    tick();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h0000_0013; bus.ifu_rsp_ready = 1'b1; #1;
    chk("fetch_rsp_valid", 32'(bus.ifu_rsp_valid), 1);
    chk("fetch_rsp_instr", bus.ifu_rsp_instr, 32'h13);
    chk("fetch_lsu_rsp", 32'(bus.lsu_rsp_valid), 0);
    tick(); clear(); #1;
    chk("fetch_done_busy", 32'(arb_busy), 0);

    // first conflict after reset, then alternation
    do_reset();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0100; bus.mem_req_ready = 1'b1;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_1000; bus.lsu_req_wen = 1'b1;
    bus.lsu_req_wmask = 4'hF; bus.lsu_req_wdata = 32'hDEAD_BEEF; #1;
    chk("conf1_ifu_ready", 32'(bus.ifu_req_ready), 1);
    chk("conf1_lsu_ready", 32'(bus.lsu_req_ready), 0);
    chk("conf1_addr", bus.mem_req_addr, 32'h8000_0100);
    tick();
    bus.ifu_req_pc = 32'h8000_0104;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h1234_5678; bus.ifu_rsp_ready = 1'b1; #1;
    chk("conf1_wait_lsu_ready", 32'(bus.lsu_req_ready), 0);
    chk("conf1_wait_busy", 32'(arb_busy), 1);
    tick(); bus.mem_rsp_valid = 1'b0; #1;
    chk("conf2_lsu_ready", 32'(bus.lsu_req_ready), 1);
    chk("conf2_ifu_ready", 32'(bus.ifu_req_ready), 0);
    chk("conf2_addr", bus.mem_req_addr, 32'h8000_1000);
    chk("conf2_wen", 32'(bus.mem_req_wen), 1);
    chk("conf2_wmask", 32'(bus.mem_req_wmask), 32'hF);
    chk("conf2_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hCAFE_F00D; bus.lsu_rsp_ready = 1'b1; #1;
    chk("conf2_lsu_rsp", 32'(bus.lsu_rsp_valid), 1);
    chk("conf2_lsu_rdata", bus.lsu_rsp_rdata, 32'hCAFE_F00D);
    chk("conf2_ifu_rsp", 32'(bus.ifu_rsp_valid), 0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_2000; bus.lsu_req_wen = 1'b0; #1;
    chk("conf3_ifu_ready", 32'(bus.ifu_req_ready), 1);
    chk("conf3_lsu_ready", 32'(bus.lsu_req_ready), 0);
    chk("conf3_addr", bus.mem_req_addr, 32'h8000_0104);
    tick();

    // LSU blocked while fetch is outstanding, with response backpressure
    bus.ifu_req_valid = 1'b0; bus.ifu_rsp_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h0000_0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_mem_rsp_ready", 32'(bus.mem_rsp_ready), 0);
      chk("bp_busy", 32'(arb_busy), 1);
      chk("bp_lsu_blocked", 32'(bus.lsu_req_ready), 0);
      chk("bp_ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 1);
      tick();
    end
    bus.ifu_rsp_ready = 1'b1; #1;
    chk("bp_hs_ready", 32'(bus.mem_rsp_ready), 1);
    tick(); bus.mem_rsp_valid = 1'b0; #1;
    chk("bp_idle_busy", 32'(arb_busy), 0);
    chk("bp_lsu_granted", 32'(bus.lsu_req_ready), 1);
    tick();

    // reset while LSU transaction is outstanding
    bus.lsu_req_valid = 1'b0; bus.ifu_req_valid = 1'b1;
    bus.mem_rsp_valid = 1'b1; bus.lsu_rsp_ready = 1'b1;
    rst = 1'b1; #1;
    chk("midrst_busy", 32'(arb_busy), 0);
    chk("midrst_lsu_rsp", 32'(bus.lsu_rsp_valid), 0);
    chk("midrst_mem_rsp_ready", 32'(bus.mem_rsp_ready), 0);
    chk("midrst_mem_req_valid", 32'(bus.mem_req_valid), 0);
    chk("midrst_ifu_ready", 32'(bus.ifu_req_ready), 0);
    tick();
    rst = 1'b0; bus.mem_rsp_valid = 1'b0; bus.lsu_req_valid = 1'b1; #1;
    chk("postrst_ifu_wins", 32'(bus.ifu_req_ready), 1);
    chk("postrst_busy", 32'(arb_busy), 0);
    tick();

    // five back-to-back conflicts alternate IFU, LSU, IFU, LSU, IFU
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'(k * 4);
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h9000_0000 + 32'(k);
      bus.mem_req_ready = 1'b1; #1;
      chk("alt_lsu_grant", 32'(bus.lsu_req_ready), 32'(k % 2));
      chk("alt_ifu_grant", 32'(bus.ifu_req_ready), 32'((k + 1) % 2));
      tick();
      bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.ifu_rsp_ready = 1'b1; bus.lsu_rsp_ready = 1'b1;
      tick();
      bus.mem_rsp_valid = 1'b0;
    end
`ifdef BIU_ARB_PERF_CNT_EN
    chk("alt_perf_ifu", p_ifu, 3);
    chk("alt_perf_lsu", p_lsu, 2);
    chk("alt_perf_conf", p_conf, 5);
`endif

    // random traffic against the reference model
    do_reset();
    busy = 0; own = 0; prev = 1; ip = 0; lp = 0; g_i = 0; g_l = 0; conf = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; ipc = $urandom; end
      if (!lp && $urandom_range(0, 2) != 0) begin
        lp = 1; laddr = $urandom; lwen = 1'($urandom_range(0, 1));
        lwd = $urandom; lwm = 4'($urandom_range(0, 15));
      end
      mr = ($urandom_range(0, 3) != 0); mrv = 1'($urandom_range(0, 1));
      ir = 1'($urandom_range(0, 1)); lr = 1'($urandom_range(0, 1)); rd = $urandom;
      bus.ifu_req_valid = ip; bus.ifu_req_pc = ipc;
      bus.lsu_req_valid = lp; bus.lsu_req_addr = laddr; bus.lsu_req_wen = lwen;
      bus.lsu_req_wdata = lwd; bus.lsu_req_wmask = lwm;
      bus.mem_req_ready = mr; bus.mem_rsp_valid = mrv; bus.mem_rsp_rdata = rd;
      bus.ifu_rsp_ready = ir; bus.lsu_rsp_ready = lr;
      #1;
      if (!busy) begin
        win = (ip && lp) ? !prev : lp;
        chk("rnd_req_valid", 32'(bus.mem_req_valid), 32'(ip | lp));
        if (ip || lp) begin
          chk("rnd_addr", bus.mem_req_addr, win ? laddr : ipc);
          chk("rnd_wen", 32'(bus.mem_req_wen), win ? 32'(lwen) : 0);
          chk("rnd_wdata", bus.mem_req_wdata, win ? lwd : 0);
          chk("rnd_wmask", 32'(bus.mem_req_wmask), win ? 32'(lwm) : 0);
        end
        chk("rnd_ifu_ready", 32'(bus.ifu_req_ready), 32'(ip && !win && mr));
        chk("rnd_lsu_ready", 32'(bus.lsu_req_ready), 32'(lp && win && mr));
        chk("rnd_idle_rsp", 32'({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_rsp_ready}), 0);
        chk("rnd_idle_busy", 32'(arb_busy), 0);
        if (ip && lp) conf++;
        if ((ip || lp) && mr) begin
          busy = 1; own = win; prev = win;
          if (win) begin g_l++; lp = 0; end else begin g_i++; ip = 0; end
        end
      end else begin
        chk("rnd_wait_req", 32'({bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready}), 0);
        chk("rnd_wait_busy", 32'(arb_busy), 1);
        chk("rnd_ifu_rsp", 32'(bus.ifu_rsp_valid), 32'(mrv && !own));
        chk("rnd_lsu_rsp", 32'(bus.lsu_rsp_valid), 32'(mrv && own));
        chk("rnd_rsp_ready", 32'(bus.mem_rsp_ready), own ? 32'(lr) : 32'(ir));
        if (mrv) chk("rnd_rsp_data", own ? bus.lsu_rsp_rdata : bus.ifu_rsp_instr, rd);
        if (mrv && (own ? lr : ir)) busy = 0;
      end
      tick();
    end
`ifdef BIU_ARB_PERF_CNT_EN
    chk("rnd_perf_ifu", p_ifu, 32'(g_i));
    chk("rnd_perf_lsu", p_lsu, 32'(g_l));
    chk("rnd_perf_conf", p_conf, 32'(conf));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu_mem_arbiter.md
Name: biu_mem_arbiter

Overview:
Two-master arbiter that shares the single instruction/data memory port between the fetch unit's request/response channel and the load-store unit.
- Sits between the fetch unit, the LSU and the memory/bus bridge.
- Round-robin grant; one outstanding transaction at a time.
- Routes each response to the owner of the granted request.
- Sequential core: IDLE/WAIT_RSP FSM, owner register, last-served pointer.

Parameters:
ADDR_W, `PC_SIZE (32), request address width
DATA_W, `XLEN (32), data width
MASK_W, DATA_W/8, byte-write-mask width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  fetch request valid
ifu_req_ready  out  1  fetch request accepted
ifu_req_pc  in  ADDR_W  fetch address (read only)
ifu_rsp_valid  out  1  fetch response valid
ifu_rsp_ready  in  1  fetch unit can take response
ifu_rsp_instr  out  DATA_W  fetched instruction
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted
lsu_req_addr  in  ADDR_W  LSU address
lsu_req_wen  in  1  1=write, 0=read
lsu_req_wdata  in  DATA_W  write data
lsu_req_wmask  in  MASK_W  byte enables
lsu_rsp_valid  out  1  LSU response valid
lsu_rsp_ready  in  1  LSU can take response
lsu_rsp_rdata  out  DATA_W  read data (undefined for writes)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  muxed address
mem_req_wen  out  1  muxed write enable (0 for fetch)
mem_req_wdata  out  DATA_W  muxed write data (0 for fetch)
mem_req_wmask  out  MASK_W  muxed mask (0 for fetch)
mem_rsp_valid  in  1  memory response valid
mem_rsp_ready  out  1  arbiter can take response
mem_rsp_rdata  in  DATA_W  response data
arb_busy  out  1  1 while in WAIT_RSP

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, owner=IFU, last_served=LSU, so fetch wins the first conflict after boot.
- While rst=1, all valid/ready outputs and arb_busy are 0.
- State IDLE:
  - sel = the only valid requester; if both are valid, sel = the requester not equal to last_served.
  - mem_req_valid = ifu_req_valid | lsu_req_valid.
  - mem_req_* fields are muxed combinationally from sel.
  - sel's req_ready = mem_req_ready; the other requester's req_ready = 0.
  - On mem_req handshake: owner<=sel, last_served<=sel, go to WAIT_RSP next cycle.
  - Latency: request to memory in 0 cycles (combinational).
- State WAIT_RSP:
  - mem_req_valid=0; both req_ready=0; arb_busy=1.
  - Owner's rsp_valid = mem_rsp_valid; owner's rsp data = mem_rsp_rdata; mem_rsp_ready = owner's rsp_ready.
  - Non-owner rsp_valid=0.
  - On rsp handshake: return to IDLE next cycle.
- No new grant is made in the same cycle as a response handshake: minimum one IDLE cycle between transactions.
- Requesters hold valid and payload stable until their req_ready; the arbiter does not latch payload.
- Selection is stable within a cycle and may change between cycles only if neither requester handshook.
- A request arriving in WAIT_RSP waits; it is never dropped.
- mem_rsp_valid in IDLE (protocol error): mem_rsp_ready=0, nothing forwarded.
- Reset asserted mid-transaction: FSM returns to IDLE; the in-flight response is discarded; the memory side is reset by the same rst.

Optional Feature:
- Macro: BIU_ARB_PERF_CNT_EN.
- With it defined: add outputs perf_ifu_grants, perf_lsu_grants and perf_conflict_cycles (32-bit each).
  - Grant counters increment on each granted handshake.
  - The conflict counter increments on each IDLE cycle with both requests valid.
  - All counters reset to 0 and saturate at 0xFFFF_FFFF.
- Without it: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared defines: `PC_SIZE, `XLEN, the state encodings (BIU_ARB_IDLE=1'b0, BIU_ARB_WAIT=1'b1) and the owner encodings (BIU_OWN_IFU=1'b0, BIU_OWN_LSU=1'b1).
- All flops use sirv_gnrl_dfflr.
- One sub-module: biu_rr_sel2 (combinational two-way round-robin selector taking last_served); everything else is in the top level.

Test Plan:
- Fetch only: ifu_req_valid=1 at pc 0x8000_0000, mem_req_ready=1 → mem_req_addr=0x8000_0000, wen=0, ifu_req_ready=1 same cycle.
  - Then mem_rsp_valid with rdata 0x0000_0013 two cycles later → ifu_rsp_instr=0x13, lsu_rsp_valid=0.
- First conflict after reset: both valid → IFU granted.
  - After its response both are still valid → LSU granted (addr 0x8000_1000, wen=1, wmask=0xF, wdata=0xDEAD_BEEF).
  - Third grant goes to IFU.
- Busy blocking: LSU requests while in WAIT_RSP for a fetch → lsu_req_ready=0, arb_busy=1 until the fetch response handshake.
  - LSU is granted one cycle after return to IDLE.
- Response backpressure: ifu_rsp_ready=0 for 3 cycles with mem_rsp_valid=1 → mem_rsp_ready=0 and the FSM stays in WAIT_RSP.
  - Handshake on the 4th cycle → IDLE on the next cycle.
- Reset in WAIT_RSP: rst pulsed 1 cycle → arb_busy=0 and all valid/ready outputs 0 during reset.
  - After reset the next conflict grants IFU.
- With BIU_ARB_PERF_CNT_EN: 5 alternating conflicting transactions → perf_ifu_grants=3, perf_lsu_grants=2, perf_conflict_cycles = exact count of IDLE cycles with both requests valid.
